rvv_retire_vrf_wb: RTL

- Retire write-back stage directly upstream of the vector register file write port.
- Accepts up to NUM_RT_UOP retiring uops per cycle from the ROB.
- Merges their per-byte writes into full-width per-register write-enable/data vectors, registered one cycle.
- Drives the VRF write port (vrf_wr_wenb_full / vrf_wr_data_full) plus per-slot retire pulses (rt_uop / rt_last_uop) aligned with the write.

---
 rtl/rvv_retire_vrf_wb.sv | 102 ++++++++++
 1 files changed

// File: rtl/rvv_retire_vrf_wb.sv
// Retire write-back stage: merges up to NUM_RT_UOP retiring uops into full-width
// per-register VRF write vectors, registered one cycle with aligned retire pulses.

module rvv_retire_vrf_wb_merge #(
  parameter int VLEN       = 128,
  parameter int NUM_RT_UOP = 4,
  parameter int REG_IDX    = 0,
  localparam int VLENB     = VLEN / 8
) (
  input  logic [NUM_RT_UOP-1:0]            acc,
  input  logic [NUM_RT_UOP-1:0][4:0]       vd,
  input  logic [NUM_RT_UOP-1:0][VLENB-1:0] be,
  input  logic [NUM_RT_UOP-1:0][VLEN-1:0]  data,
  output logic [VLEN-1:0]                  wenb,
  output logic [VLEN-1:0]                  wdata
);
  // Ascending slot order so the youngest accepted writer of a byte wins.
  always_comb begin
    wenb  = '0;
    wdata = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      for (int b = 0; b < VLENB; b++) begin
        if (acc[i] && vd[i] == 5'(REG_IDX) && be[i][b]) begin
          wenb[8*b +: 8]  = 8'hFF;
          wdata[8*b +: 8] = data[i][8*b +: 8];
        end
      end
    end
  end
endmodule

module rvv_retire_vrf_wb #(
  parameter int VLEN       = 128,
  parameter int NUM_RT_UOP = 4,
  localparam int VLENB     = VLEN / 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RT_UOP-1:0]             rt_valid,
  output logic [NUM_RT_UOP-1:0]             rt_ready,
  input  logic [NUM_RT_UOP-1:0][4:0]        rt_vd,
  input  logic [NUM_RT_UOP-1:0][VLENB-1:0]  rt_be,
  input  logic [NUM_RT_UOP-1:0][VLEN-1:0]   rt_data,
  input  logic [NUM_RT_UOP-1:0]             rt_last,
  input  logic                              vrf_wr_busy,
  output logic [31:0][VLEN-1:0]             vrf_wr_wenb_full,
  output logic [31:0][VLEN-1:0]             vrf_wr_data_full,
  output logic [NUM_RT_UOP-1:0]             rt_uop,
  output logic [NUM_RT_UOP-1:0]             rt_last_uop,
  output logic [31:0]                       retire_cnt
);
  logic [NUM_RT_UOP-1:0]   acc;
  logic [31:0][VLEN-1:0]   wenb_nxt;
  logic [31:0][VLEN-1:0]   data_nxt;
  logic [31:0]             pop;

  // Only a contiguous prefix from slot 0 may retire.
  always_comb begin
    logic chain;
    chain = rst_n & ~vrf_wr_busy;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      rt_ready[i] = chain;
      chain       = chain & rt_valid[i];
    end
  end

  assign acc = rt_valid & rt_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) pop = pop + 32'(acc[i]);
  end

  for (genvar r = 0; r < 32; r++) begin : g_reg
    rvv_retire_vrf_wb_merge #(
      .VLEN(VLEN), .NUM_RT_UOP(NUM_RT_UOP), .REG_IDX(r)
    ) u_merge (
      .acc  (acc),
      .vd   (rt_vd),
      .be   (rt_be),
      .data (rt_data),
      .wenb (wenb_nxt[r]),
      .wdata(data_nxt[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vrf_wr_wenb_full <= '0;
      vrf_wr_data_full <= '0;
      rt_uop           <= '0;
      rt_last_uop      <= '0;
      retire_cnt       <= '0;
    end else begin
      vrf_wr_wenb_full <= wenb_nxt;
      vrf_wr_data_full <= data_nxt;
      rt_uop           <= acc;
      rt_last_uop      <= acc & rt_last;
      retire_cnt       <= retire_cnt + pop;
    end
  end
endmodule
